// File: rtl/fifo_sync_v2.sv
// fifo_sync_v2: parametrised single-clock FIFO with fill level, programmable
// almost-full/almost-empty thresholds, read+write while full and sticky error
// flags. Any DEPTH >= 2 is supported; pointers wrap by explicit compare.
// Define FIFO_SYNC_V2_FWFT_EN for a first-word-fall-through read port
// (dout shows the head word combinationally and rd_en acknowledges a pop).
// Without the macro, dout is registered and valid one cycle after rd_en.
module fifo_sync_v2 #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int LVL_W  = $clog2(DEPTH + 1),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  input  logic [LVL_W-1:0] af_thresh,
  input  logic [LVL_W-1:0] ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err,
  output logic             ovf_sticky,
  output logic             udf_sticky
);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  logic              udf_sticky_q, udf_sticky_d;
  logic              wr_ok, rd_ok;

  // Status flags decode the registered level; thresholds are used live.
  assign level        = level_q;
  assign full         = (level_q == LVL_W'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign ovf_sticky   = ovf_sticky_q;
  assign udf_sticky   = udf_sticky_q;

  // Acceptance, pointer/level next state and error flag next state.
  always_comb begin
    rd_ok        = rd_en && !empty;
    wr_ok        = wr_en && (!full || rd_ok);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overflow_d   = wr_en && !wr_ok;
    underflow_d  = rd_en && !rd_ok;
    // A new error on this edge wins over a coincident clear.
    ovf_sticky_d = overflow_d  ? 1'b1 : (clr_err ? 1'b0 : ovf_sticky_q);
    udf_sticky_d = underflow_d ? 1'b1 : (clr_err ? 1'b0 : udf_sticky_q);
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage array; not reset. A read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

`ifdef FIFO_SYNC_V2_FWFT_EN
  // Head word is always presented; valid whenever something is stored.
  assign dout       = mem[rd_ptr_q];
  assign dout_valid = !empty;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  // Registered read port: capture the head on an accepted read, else hold.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = rd_ok;
    if (rd_ok) begin
      dout_d = mem[rd_ptr_q];
    end
  end

  // Read data register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Bench for fifo_sync_v2: a DEPTH=16 instance checked cycle by cycle against a
// queue-based reference model, plus a DEPTH=5 instance for pointer wrap.
module tb_fifo_sync_v2;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int D5    = 5;
  localparam int L5    = $clog2(D5 + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0]       din = '0;
  logic [LVL_W-1:0] af_thresh = '0, ae_thresh = '0;
  logic [7:0]       dout;
  logic             dout_valid, full, empty, almost_full, almost_empty;
  logic [LVL_W-1:0] level;
  logic             overflow, underflow, ovf_sticky, udf_sticky;

  logic             d5_wr = 1'b0, d5_rd = 1'b0;
  logic [7:0]       d5_din = '0;
  logic [L5-1:0]    d5_af = L5'(D5), d5_ae = '0;
  logic [7:0]       d5_dout;
  logic             d5_dv, d5_full, d5_empty, d5_afull, d5_aempty;
  logic [L5-1:0]    d5_level;
  logic             d5_ovf, d5_udf, d5_ovs, d5_uds;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_sync_v2 #(.DEPTH(DEPTH), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
    .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  fifo_sync_v2 #(.DEPTH(D5), .WIDTH(8)) u_dut5 (
    .clk(clk), .rst(rst), .wr_en(d5_wr), .din(d5_din), .rd_en(d5_rd),
    .dout(d5_dout), .dout_valid(d5_dv), .full(d5_full), .empty(d5_empty),
    .af_thresh(d5_af), .ae_thresh(d5_ae),
    .almost_full(d5_afull), .almost_empty(d5_aempty), .level(d5_level),
    .overflow(d5_ovf), .underflow(d5_udf), .clr_err(1'b0),
    .ovf_sticky(d5_ovs), .udf_sticky(d5_uds)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the FIFO contents as a queue plus observed flags.
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_dv, m_ovf, m_udf, m_ovs, m_uds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0; m_ovs = 0; m_uds = 0;
  endtask

  task automatic model_edge();
    int sz;
    bit rok, wok;
    logic [7:0] h;
    sz  = mq.size();
    rok = rd_en && (sz > 0);
    wok = wr_en && ((sz < DEPTH) || rok);
    h   = '0;
    if (rok) h = mq.pop_front();
    if (wok) mq.push_back(din);
    m_ovf = wr_en && !wok;
    m_udf = rd_en && !rok;
    m_ovs = m_ovf ? 1'b1 : (clr_err ? 1'b0 : m_ovs);
    m_uds = m_udf ? 1'b1 : (clr_err ? 1'b0 : m_uds);
    if (rok) begin m_dout = h; m_dv = 1; end
    else m_dv = 0;
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    check("level", 32'(level), sz);
    check("full", 32'(full), 32'(sz == DEPTH));
    check("empty", 32'(empty), 32'(sz == 0));
    check("almost_full", 32'(almost_full), 32'(sz >= int'(af_thresh)));
    check("almost_empty", 32'(almost_empty), 32'(sz <= int'(ae_thresh)));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_udf));
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovs));
    check("udf_sticky", 32'(udf_sticky), 32'(m_uds));
`ifdef FIFO_SYNC_V2_FWFT_EN
    check("dout_valid", 32'(dout_valid), 32'(sz > 0));
    if (sz > 0) check("dout", 32'(dout), 32'(mq[0]));
`else
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    check("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr_en = w; rd_en = r; din = d; clr_err = c;
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         lvl;
    bit         ovf;
    bit         udf;
    bit         dv;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int ovf_cnt, udf_cnt, maxlvl, p;
    logic [7:0] got[$];

    tbl[0] = '{1, 0, 8'h11, 1, 0, 0, 0, 8'h00};
    tbl[1] = '{1, 0, 8'h22, 2, 0, 0, 0, 8'h00};
    tbl[2] = '{0, 1, 8'h00, 1, 0, 0, 1, 8'h11};
    tbl[3] = '{1, 1, 8'h33, 1, 0, 0, 1, 8'h22};
    tbl[4] = '{0, 1, 8'h00, 0, 0, 0, 1, 8'h33};
    tbl[5] = '{0, 1, 8'h00, 0, 0, 1, 0, 8'h33};
    tbl[6] = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h33};
    tbl[7] = '{1, 1, 8'h55, 1, 0, 1, 0, 8'h33};
    tbl[8] = '{0, 1, 8'h00, 0, 0, 0, 1, 8'h55};

    // Reset state, with af_thresh = 0 so almost_full reads 1.
    model_reset();
    #12;
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull_thr0", 32'(almost_full), 1);
    check("rst_dout_valid", 32'(dout_valid), 0);
`ifndef FIFO_SYNC_V2_FWFT_EN
    check("rst_dout", 32'(dout), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    af_thresh = LVL_W'(12);
    ae_thresh = LVL_W'(3);
    #1;
    check("afull_thr12_empty", 32'(almost_full), 0);

    // Table of short vectors, including read+write on an empty FIFO.
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0);
      step();
      check($sformatf("tbl%0d_level", i), 32'(level), tbl[i].lvl);
      check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_udf", i), 32'(underflow), 32'(tbl[i].udf));
`ifndef FIFO_SYNC_V2_FWFT_EN
      check($sformatf("tbl%0d_dv", i), 32'(dout_valid), 32'(tbl[i].dv));
      check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
`endif
    end
    check("wr_rd_empty_udf_sticky", 32'(udf_sticky), 1);

    // Clear stickies, then fill 0x01..0x10 and drain in order.
    set_in(0, 0, 8'h00, 1); step();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0, 8'(i + 1), 0); step();
    end
    check("fill_full", 32'(full), 1);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_SYNC_V2_FWFT_EN
      check("drain_head", 32'(dout), 32'(i + 1));
`endif
      set_in(0, 1, 8'h00, 0); step();
`ifndef FIFO_SYNC_V2_FWFT_EN
      check("drain_dout", 32'(dout), 32'(i + 1));
`endif
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_no_ovf", 32'(ovf_sticky), 0);
    check("drain_no_udf", 32'(udf_sticky), 0);

    // Full with simultaneous read and write of 0xAA.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0, 8'(8'h40 + i), 0); step();
    end
    set_in(1, 1, 8'hAA, 0); step();
    check("fullrw_level", 32'(level), DEPTH);
    check("fullrw_ovf", 32'(overflow), 0);
`ifndef FIFO_SYNC_V2_FWFT_EN
    check("fullrw_old_head", 32'(dout), 32'h40);
`endif
    for (int i = 0; i < DEPTH - 1; i++) begin
      set_in(0, 1, 8'h00, 0); step();
    end
`ifdef FIFO_SYNC_V2_FWFT_EN
    check("fullrw_aa_head", 32'(dout), 32'hAA);
`endif
    set_in(0, 1, 8'h00, 0); step();
`ifndef FIFO_SYNC_V2_FWFT_EN
    check("fullrw_aa_read", 32'(dout), 32'hAA);
`endif

    // Threshold ramp up and down; overflow coinciding with clr_err.
    for (int i = 1; i <= DEPTH; i++) begin
      set_in(1, 0, 8'(i), 0); step();
      check("ramp_afull", 32'(almost_full), 32'(i >= 12));
      check("ramp_aempty", 32'(almost_empty), 32'(i <= 3));
    end
    set_in(1, 0, 8'hEE, 1); step();
    check("ovf_clr_pulse", 32'(overflow), 1);
    check("ovf_clr_sticky", 32'(ovf_sticky), 1);
    set_in(0, 0, 8'h00, 1); step();
    check("clr_sticky", 32'(ovf_sticky), 0);
    check("clr_pulse_gone", 32'(overflow), 0);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      set_in(0, 1, 8'h00, 0); step();
      check("rampdn_afull", 32'(almost_full), 32'(i >= 12));
      check("rampdn_aempty", 32'(almost_empty), 32'(i <= 3));
    end
    set_in(0, 0, 8'h00, 0);

    // DEPTH=5 instance: 7 writes then 7 reads, three rounds.
    for (int r = 0; r < 3; r++) begin
      ovf_cnt = 0; udf_cnt = 0; maxlvl = 0; got.delete();
      for (int i = 0; i < 7; i++) begin
        d5_wr = 1; d5_din = 8'(r * 16 + i);
        step();
        if (d5_ovf) ovf_cnt++;
        if (int'(d5_level) > maxlvl) maxlvl = int'(d5_level);
        check("d5_wr_level", 32'(d5_level), (i + 1 > D5) ? D5 : i + 1);
      end
      d5_wr = 0;
      for (int i = 0; i < 7; i++) begin
        d5_rd = 1;
`ifdef FIFO_SYNC_V2_FWFT_EN
        if (d5_dv) got.push_back(d5_dout);
`endif
        step();
        if (d5_udf) udf_cnt++;
`ifndef FIFO_SYNC_V2_FWFT_EN
        if (d5_dv) got.push_back(d5_dout);
`endif
      end
      d5_rd = 0;
      step();
      check("d5_ovf_count", ovf_cnt, 2);
      check("d5_udf_count", udf_cnt, 2);
      check("d5_max_level_ok", 32'(maxlvl <= D5), 1);
      check("d5_read_count", got.size(), D5);
      for (int i = 0; i < got.size(); i++)
        check("d5_data", 32'(got[i]), 32'(r * 16 + i));
    end

`ifdef FIFO_SYNC_V2_FWFT_EN
    // Fall-through: a word written into an empty FIFO shows without rd_en.
    set_in(1, 0, 8'h33, 0); step();
    check("fwft_dout", 32'(dout), 32'h33);
    check("fwft_dv", 32'(dout_valid), 1);
    set_in(0, 1, 8'h00, 0); step();
    check("fwft_pop_empty", 32'(empty), 1);
`endif

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 8'(8'hC0 + i), 0); step();
    end
    set_in(0, 1, 8'h00, 0); step();
    set_in(0, 0, 8'h00, 0);
    #2 rst = 1'b1;
    #1;
    check("amid_rst_level", 32'(level), 0);
    check("amid_rst_dv", 32'(dout_valid), 0);
    check("amid_rst_empty", 32'(empty), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 0, 8'h77, 0); step();
    set_in(0, 1, 8'h00, 0); step();

    // Randomised traffic against the model.
    p = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) p = 20 + 30 * int'($urandom_range(2));
      if (c % 100 == 0) begin
        af_thresh = LVL_W'($urandom_range(0, 20));
        ae_thresh = LVL_W'($urandom_range(0, 20));
      end
      set_in($urandom_range(99) < p, $urandom_range(99) < (100 - p),
             8'($urandom), $urandom_range(7) == 0);
      step();
    end
    set_in(0, 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_v2.md
Name: fifo_sync_v2

Overview:
Parametrised single-clock FIFO, the next-generation successor to the team's 16x8 FIFO. Adds:
- arbitrary (non-power-of-2) depth;
- a fill-level output;
- programmable almost-full and almost-empty thresholds;
- read+write while full;
- sticky error flags with clear;
- an optional first-word-fall-through (FWFT) read port.

It sits between producer and consumer datapaths in the same clock domain.

Parameters:
DEPTH, 16, number of storage words; legal range is 2 or more, any integer.
WIDTH, 8, data word width in bits.
LVL_W, $clog2(DEPTH+1), width of level and threshold signals (derived; do not override).
ADDR_W, $clog2(DEPTH), pointer width (derived).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request (pop acknowledge in FWFT mode)
dout  out  WIDTH  read data
dout_valid  out  1  dout holds a valid word (see Behaviour)
full  out  1  level == DEPTH
empty  out  1  level == 0
af_thresh  in  LVL_W  almost-full threshold
ae_thresh  in  LVL_W  almost-empty threshold
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh
level  out  LVL_W  words currently stored, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected
clr_err  in  1  clears sticky flags
ovf_sticky  out  1  set by any overflow, held until clr_err
udf_sticky  out  1  set by any underflow, held until clr_err

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, level=0, dout=0, dout_valid=0, overflow=0, underflow=0, ovf_sticky=0, udf_sticky=0.
  - Consequently full=0, empty=1, almost_empty=1, almost_full=(af_thresh==0).
  - Memory array is not reset.
  - Reset mid-operation discards all contents immediately (async); the first write after reset deassertion lands at address 0.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, not natural overflow), so non-power-of-2 DEPTH is supported.
- Acceptance is evaluated against registered level at the clock edge:
  - wr_ok = wr_en && (!full || rd_ok)
  - rd_ok = rd_en && !empty
- Level update:
  - +1 on wr_ok only;
  - -1 on rd_ok only;
  - unchanged on both or neither.
  - level never exceeds DEPTH and never wraps below 0.
- Full and read+write: both accepted, level stays DEPTH. The write lands in the slot being read; the read returns the old word (read-before-write on the same edge).
- Empty and read+write: write accepted, read rejected, underflow pulses, level becomes 1.
- Error pulses:
  - overflow=1 for exactly the cycle after an edge with wr_en && !wr_ok.
  - underflow=1 for exactly the cycle after an edge with rd_en && !rd_ok.
- Sticky flags:
  - Set on the same edge that raises the corresponding pulse.
  - clr_err clears them; if set and clear coincide, set wins.
- Flags full, empty, almost_full and almost_empty are combinational decodes of registered level, so they change in the cycle after the causing edge.
- Thresholds are sampled live, with no registering.
  - af_thresh > DEPTH means almost_full is never asserted.
- Standard read mode (macro undefined):
  - On rd_ok, dout <= mem[rd_ptr] and dout_valid=1 for one cycle. Latency is 1 cycle from the rd_en edge.
  - Otherwise dout holds its last value and dout_valid=0.
- No FSM; the state is fully captured by {wr_ptr, rd_ptr, level}.

Optional Feature:
Macro: FIFO_SYNC_V2_FWFT_EN.
- Defined (FWFT):
  - dout = mem[rd_ptr] combinationally; dout_valid = !empty.
  - rd_en is a pop acknowledge for the word already visible; the next word appears in the cycle after the pop.
  - A word written into an empty FIFO is visible on dout one cycle after the write edge.
  - All acceptance, level, flag and error rules are unchanged.
- Undefined: standard registered read port as described above; dout is reset to 0.

Test Plan:
1. Reset, then write 0x01..0x10 (DEPTH=16), then read 16 times -> data out 0x01..0x10 in order with 1-cycle latency; full=1 after the 16th write; empty=1 after the 16th read; no error pulses.
2. DEPTH=5: write 7 times, read 7 times, repeated for 3 rounds -> pointer wrap at 4->0 is correct; data stream is in order; level is never >5; exactly 2 overflow pulses and 2 underflow pulses per round.
3. Fill to full, then wr_en=rd_en=1 with din=0xAA -> old head word is read; level stays 16; overflow=0; the 0xAA entry appears after 15 further reads.
4. Empty FIFO, wr_en=rd_en=1 with din=0x55 -> underflow pulses 1 cycle; udf_sticky=1; level=1; the next read returns 0x55.
5. af_thresh=12, ae_thresh=3: ramp level from 0 to 16 and back -> almost_full asserted exactly at level>=12; almost_empty asserted exactly at level<=3; overflow with clr_err in the same cycle leaves ovf_sticky=1.
6. FWFT build: write 0x33 into the empty FIFO -> dout=0x33 and dout_valid=1 the next cycle with no rd_en; rd_en pops it and empty=1 the following cycle; assert rst mid-stream -> level=0 and dout_valid=0 immediately.
